// File: rtl/gibbs_sweep_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gibbs_sweep_controller_pkg
// Description : Shared segment-type and flag codes plus the sweep FSM states.
// Revision    : 1.0  initial release
// ============================================================================
package gibbs_sweep_controller_pkg;

   // Segment types returned by the segment selector
   localparam logic [1:0] EXPDOWN = 2'd1;
   localparam logic [1:0] EXPUP   = 2'd2;
   localparam logic [1:0] UNIFORM = 2'd3;

   // Constraint flags returned by the bound calculator
   localparam logic [1:0] FLAG_NONE = 2'd0;
   localparam logic [1:0] FLAG_LT   = 2'd1;
   localparam logic [1:0] FLAG_GT   = 2'd2;
   localparam logic [1:0] FLAG_BOTH = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_BOUND    = 3'd1,
      S_SEG      = 3'd2,
      S_SEGWAIT  = 3'd3,
      S_SAMP     = 3'd4,
      S_SAMPWAIT = 3'd5,
      S_WRITE    = 3'd6,
      S_NEXT     = 3'd7
   } state_t;

endpackage
`default_nettype wire

// File: rtl/gibbs_sweep_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : gibbs_sweep_controller_if
// Description : Control, bound, segment, sampler and register-file signals
//               seen by the sweep controller (master) and its peers (slave).
// Revision    : 1.0  initial release
// ============================================================================
interface gibbs_sweep_controller_if #(
   parameter int WIDTH   = 8,
   parameter int IDX_W   = 2,
   parameter int SWEEP_W = 8
);
   logic                     in_start;
   logic [SWEEP_W-1:0]       in_num_sweeps;
   logic                     out_busy;
   logic                     out_done;
   logic                     out_err;
   logic                     out_bound_req;
   logic [IDX_W-1:0]         out_var_idx;
   logic                     in_bound_valid;
   logic [1:0]               in_flag;
   logic                     out_seg_enable;
   logic [1:0]               in_seg_type;
   logic signed [WIDTH-1:0]  in_seg_from;
   logic signed [WIDTH-1:0]  in_seg_to;
   logic signed [WIDTH-1:0]  in_min_variable;
   logic signed [WIDTH-1:0]  in_max_variable;
   logic                     out_samp_start;
   logic [1:0]               out_samp_type;
   logic signed [WIDTH-1:0]  out_samp_from;
   logic signed [WIDTH-1:0]  out_samp_to;
   logic                     in_samp_valid;
   logic signed [WIDTH-1:0]  in_samp_value;
   logic                     out_wr_en;
   logic [IDX_W-1:0]         out_wr_addr;
   logic signed [WIDTH-1:0]  out_wr_data;

   modport master (
      input  in_start, in_num_sweeps, in_bound_valid, in_flag,
             in_seg_type, in_seg_from, in_seg_to,
             in_min_variable, in_max_variable, in_samp_valid, in_samp_value,
      output out_busy, out_done, out_err, out_bound_req, out_var_idx,
             out_seg_enable, out_samp_start, out_samp_type, out_samp_from,
             out_samp_to, out_wr_en, out_wr_addr, out_wr_data
   );

   modport slave (
      output in_start, in_num_sweeps, in_bound_valid, in_flag,
             in_seg_type, in_seg_from, in_seg_to,
             in_min_variable, in_max_variable, in_samp_valid, in_samp_value,
      input  out_busy, out_done, out_err, out_bound_req, out_var_idx,
             out_seg_enable, out_samp_start, out_samp_type, out_samp_from,
             out_samp_to, out_wr_en, out_wr_addr, out_wr_data
   );
endinterface
`default_nettype wire

// File: rtl/gibbs_sweep_controller_sweep_counter.sv
`default_nettype none
// ============================================================================
// Module      : gibbs_sweep_controller_sweep_counter
// Description : Variable index and sweep counters with wrap and terminal
//               count flags. The sweep target is captured on clear.
// Revision    : 1.0  initial release
// ============================================================================
module gibbs_sweep_controller_sweep_counter #(
   parameter int NUM_VARS = 4,
   parameter int IDX_W    = 2,
   parameter int SWEEP_W  = 8
) (
   input  wire logic               clock,
   input  wire logic               reset_n,
   input  wire logic               clear,
   input  wire logic               step,
   input  wire logic [SWEEP_W-1:0] target,
   output logic [IDX_W-1:0]        idx,
   output logic [IDX_W-1:0]        next_idx,
   output logic                    last_var,
   output logic                    last_sweep
);
   logic [SWEEP_W-1:0] sweep_cnt;
   logic [SWEEP_W-1:0] target_q;

   assign last_var   = (idx == IDX_W'(NUM_VARS - 1));
   assign next_idx   = last_var ? '0 : idx + IDX_W'(1);
   // True when the sweep that is finishing now is the final one
   assign last_sweep = ((sweep_cnt + SWEEP_W'(1)) == target_q);

   // Restart on clear; advance the index and roll the sweep count on wrap
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         idx       <= '0;
         sweep_cnt <= '0;
         target_q  <= '0;
      end else if (clear) begin
         idx       <= '0;
         sweep_cnt <= '0;
         target_q  <= target;
      end else if (step) begin
         idx <= next_idx;
         if (last_var) begin
            sweep_cnt <= sweep_cnt + SWEEP_W'(1);
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/gibbs_sweep_controller.sv
`default_nettype none
// ============================================================================
// Module      : gibbs_sweep_controller
// Description : Walks every variable through bound request, segment select,
//               in-segment sampling and register-file write-back, for the
//               requested number of sweeps.
// Revision    : 1.0  initial release
// ============================================================================
module gibbs_sweep_controller #(
   parameter int WIDTH    = 8,
   parameter int NUM_VARS = 4,
   parameter int IDX_W    = 2,
   parameter int SWEEP_W  = 8,
   parameter int SEG_LAT  = 2
) (
   input wire logic                  in_clock,
   input wire logic                  in_reset,
   gibbs_sweep_controller_if.master  bus
);
   import gibbs_sweep_controller_pkg::*;

   localparam int LAT_W = (SEG_LAT > 1) ? $clog2(SEG_LAT) : 1;

   state_t             state;
   logic [LAT_W-1:0]   lat_cnt;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   next_idx;
   logic               last_var;
   logic               last_sweep;
   logic               clear_cnt;
   logic               step_cnt;

   assign clear_cnt = (state == S_IDLE) && bus.in_start;
   assign step_cnt  = (state == S_NEXT);

   gibbs_sweep_controller_sweep_counter #(
      .NUM_VARS (NUM_VARS),
      .IDX_W    (IDX_W),
      .SWEEP_W  (SWEEP_W)
   ) u_sweep_counter (
      .clock      (in_clock),
      .reset_n    (in_reset),
      .clear      (clear_cnt),
      .step       (step_cnt),
      .target     (bus.in_num_sweeps),
      .idx        (idx),
      .next_idx   (next_idx),
      .last_var   (last_var),
      .last_sweep (last_sweep)
   );

   // Per-variable step sequencer; every output is a register set on entry
   // to the state that owns it, pulses are cleared by default each cycle
   always_ff @(posedge in_clock or negedge in_reset) begin
      if (!in_reset) begin
         state              <= S_IDLE;
         lat_cnt            <= '0;
         bus.out_busy       <= 1'b0;
         bus.out_done       <= 1'b0;
         bus.out_err        <= 1'b0;
         bus.out_bound_req  <= 1'b0;
         bus.out_var_idx    <= '0;
         bus.out_seg_enable <= 1'b0;
         bus.out_samp_start <= 1'b0;
         bus.out_samp_type  <= '0;
         bus.out_samp_from  <= '0;
         bus.out_samp_to    <= '0;
         bus.out_wr_en      <= 1'b0;
         bus.out_wr_addr    <= '0;
         bus.out_wr_data    <= '0;
      end else begin
         bus.out_done       <= 1'b0;
         bus.out_seg_enable <= 1'b0;
         bus.out_samp_start <= 1'b0;
         bus.out_wr_en      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.in_start) begin
                  bus.out_err <= 1'b0;
                  if (bus.in_num_sweeps == '0) begin
                     bus.out_done <= 1'b1;
                  end else begin
                     state             <= S_BOUND;
                     bus.out_busy      <= 1'b1;
                     bus.out_bound_req <= 1'b1;
                     bus.out_var_idx   <= '0;
                  end
               end
            end
            S_BOUND: begin
               if (bus.in_bound_valid) begin
                  bus.out_bound_req <= 1'b0;
                  // Unconstrained variable: sample its whole range uniformly
                  if (bus.in_flag == FLAG_NONE) begin
                     bus.out_samp_type  <= UNIFORM;
                     bus.out_samp_from  <= bus.in_min_variable;
                     bus.out_samp_to    <= bus.in_max_variable;
                     bus.out_samp_start <= 1'b1;
                     state              <= S_SAMP;
                  end else begin
                     bus.out_seg_enable <= 1'b1;
                     state              <= S_SEG;
                  end
               end
            end
            S_SEG: begin
               lat_cnt <= '0;
               state   <= S_SEGWAIT;
            end
            S_SEGWAIT: begin
               if (lat_cnt == LAT_W'(SEG_LAT - 1)) begin
                  bus.out_samp_type <= bus.in_seg_type;
                  bus.out_samp_from <= bus.in_seg_from;
                  bus.out_samp_to   <= bus.in_seg_to;
                  // Single-point or inverted segment: write its lower bound directly
                  if ($signed(bus.in_seg_from) >= $signed(bus.in_seg_to)) begin
                     if ($signed(bus.in_seg_from) > $signed(bus.in_seg_to)) begin
                        bus.out_err <= 1'b1;
                     end
                     bus.out_wr_data <= bus.in_seg_from;
                     bus.out_wr_addr <= idx;
                     bus.out_wr_en   <= 1'b1;
                     state           <= S_WRITE;
                  end else begin
                     bus.out_samp_start <= 1'b1;
                     state              <= S_SAMP;
                  end
               end else begin
                  lat_cnt <= lat_cnt + LAT_W'(1);
               end
            end
            S_SAMP: begin
               state <= S_SAMPWAIT;
            end
            S_SAMPWAIT: begin
               if (bus.in_samp_valid) begin
                  bus.out_wr_data <= bus.in_samp_value;
                  bus.out_wr_addr <= idx;
                  bus.out_wr_en   <= 1'b1;
                  state           <= S_WRITE;
               end
            end
            S_WRITE: begin
               state <= S_NEXT;
            end
            S_NEXT: begin
               bus.out_var_idx <= next_idx;
               if (last_var && last_sweep) begin
                  state        <= S_IDLE;
                  bus.out_busy <= 1'b0;
                  bus.out_done <= 1'b1;
               end else begin
                  state             <= S_BOUND;
                  bus.out_bound_req <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: doc/gibbs_sweep_controller.md
Name: gibbs_sweep_controller

Overview:
- Sequences one Gibbs/MCMC sweep engine across all solver variables.
- Per variable, the step order is:
  - request constraint bounds;
  - pulse the segment selector;
  - latch the chosen segment;
  - start the in-segment sampler;
  - write the sampled value back to the variable register file.
- Sits between the sweep-level top control, the bound calculator, the segment selector (flag/c1/c2/min/max in; type/from/to out) and the segment sampler.

Parameters:
- WIDTH, 8, signed variable/value width.
- NUM_VARS, 4, number of variables per sweep.
- IDX_W, 2, variable index width; must satisfy 2**IDX_W >= NUM_VARS.
- SWEEP_W, 8, sweep counter width.
- SEG_LAT, 2, cycles from out_seg_enable high until in_seg_* is valid; minimum 1.

Ports:
- in_clock, input, 1, system clock.
- in_reset, input, 1, asynchronous active-low reset.
- in_start, input, 1, one-cycle pulse that starts in_num_sweeps sweeps.
- in_num_sweeps, input, SWEEP_W, sweeps to run; sampled on in_start.
- out_busy, output, 1, high from the cycle after an accepted start until done.
- out_done, output, 1, one-cycle pulse when all sweeps complete.
- out_err, output, 1, sticky degenerate-segment flag; cleared on in_start.
- out_bound_req, output, 1, bound request; level held until valid.
- out_var_idx, output, IDX_W, current variable index (also addresses the min/max table).
- in_bound_valid, input, 1, bound results valid.
- in_flag, input, 2, 0 none, 1 less-than, 2 more-than, 3 both.
- out_seg_enable, output, 1, one-cycle enable to the segment selector.
- in_seg_type, input, 2, chosen type: 1 EXPDOWN, 2 EXPUP, 3 UNIFORM.
- in_seg_from, input, WIDTH, signed segment lower bound.
- in_seg_to, input, WIDTH, signed segment upper bound.
- in_min_variable, input, WIDTH, signed minimum of the variable at out_var_idx.
- in_max_variable, input, WIDTH, signed maximum of the variable at out_var_idx.
- out_samp_start, output, 1, one-cycle sampler start.
- out_samp_type, output, 2, registered segment type.
- out_samp_from, output, WIDTH, registered segment lower bound.
- out_samp_to, output, WIDTH, registered segment upper bound.
- in_samp_valid, input, 1, sampler result valid.
- in_samp_value, input, WIDTH, sampled value.
- out_wr_en, output, 1, one-cycle register-file write.
- out_wr_addr, output, IDX_W, write address.
- out_wr_data, output, WIDTH, write data.

Behaviour:
- Reset (in_reset=0, asynchronous):
  - state IDLE;
  - all outputs 0;
  - sweep and variable counters 0.
  - Reset mid-operation aborts with no further write.
- IDLE:
  - in_start=1 and in_num_sweeps=0: out_done pulses the next cycle; out_busy stays 0.
  - in_start=1 and in_num_sweeps!=0: latch the count, idx=0, clear out_err, go to BOUND.
  - in_start while busy is ignored.
- BOUND: out_bound_req=1 until in_bound_valid=1 is sampled at a clock edge. Latch in_flag, in_min_variable and in_max_variable.
  - flag=0: load type 3, from=min, to=max, go to SAMP.
  - otherwise: go to SEG.
- SEG: out_seg_enable=1 for exactly one cycle, then go to SEGWAIT.
- SEGWAIT:
  - Count SEG_LAT cycles, then register in_seg_type, in_seg_from and in_seg_to into out_samp_*.
  - from==to: set wr_data=from and go to WRITE, skipping the sampler.
  - from>to (signed): set out_err=1, wr_data=from, go to WRITE.
  - otherwise: go to SAMP.
- SAMP: out_samp_start=1 for one cycle; out_samp_* held stable until the value is captured.
- SAMPWAIT: on in_samp_valid, capture in_samp_value into wr_data and go to WRITE. The valid may arrive the cycle after start; no timeout.
- WRITE: out_wr_en=1 for one cycle, with out_wr_addr=idx and out_wr_data.
- NEXT:
  - idx==NUM_VARS-1: idx wraps to 0 and the sweep count increments. If the count equals the target, go to IDLE and pulse out_done; otherwise go to BOUND.
  - else: idx++ and go to BOUND.
- Minimum per-variable latency with the sampler, with bound valid and sample valid each arriving one cycle after their request: 1 BOUND + 1 SEG + SEG_LAT + 1 SAMP + 1 SAMPWAIT + 1 WRITE + 1 NEXT = 6+SEG_LAT cycles.
- out_busy=1 in every non-IDLE state.
- out_var_idx is a registered copy of idx and is stable throughout the step.
- All comparisons on segment bounds are signed WIDTH-bit.

Decomposition:
- Shared package holds:
  - segment type constants EXPDOWN=2'd1, EXPUP=2'd2, UNIFORM=2'd3;
  - flag constants FLAG_NONE=0, FLAG_LT=1, FLAG_GT=2, FLAG_BOTH=3;
  - the state encoding.
- One natural sub-module: sweep_counter, the idx/sweep counters with wrap and terminal-count outputs.
- The FSM stays in gibbs_sweep_controller.

Test Plan:
- Reset mid-SAMPWAIT (in_reset low for 1 cycle) -> all outputs 0 immediately; no out_wr_en afterwards; next in_start runs normally.
- in_start with in_num_sweeps=0 -> out_done high exactly 1 cycle later; out_busy, out_bound_req and out_wr_en never high.
- NUM_VARS=4, in_num_sweeps=2, flag=3, seg from=-3 to=5 type 3, sampler returns idx+10 -> 8 writes with addr 0,1,2,3,0,1,2,3 and data 10..13 repeated; out_done once after the 8th write.
- flag=0, min=-8, max=7 -> out_seg_enable never asserted; out_samp_type=3, from=-8, to=7 at start.
- Segment from=4 to=4 -> no out_samp_start; write data 4. Segment from=6 to=2 -> out_err=1 and write data 6; out_err clears on the next in_start.
- Delayed handshakes: in_bound_valid 5 cycles late, in_samp_valid 7 cycles late -> out_bound_req held 5 cycles; out_samp_* stable throughout; exactly one write per variable; in_start pulses during busy ignored.
